// File: rtl/keypad_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_encoder
//  Description : Debounces the raw 10-line one-hot keypad, rejects multi-key
//                presses and emits a one-cycle valid strobe with a BCD digit
//                for every accepted press.
//                Optional auto-repeat while a key is held is enabled by
//                defining the macro KEYPAD_AUTOREPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [9:0] keypad,
  output logic [3:0] digit,
  output logic       valid,
  output logic       busy,
  output logic       error
);

  // Counters must be able to reach their terminal values.
  if ((DEBOUNCE_CYCLES < 1) || (REPEAT_CYCLES < 1) ||
      (DEBOUNCE_CYCLES >= (1 << CNT_W)) || (REPEAT_CYCLES >= (1 << CNT_W))) begin : g_param_check
    $error("keypad_encoder: DEBOUNCE_CYCLES/REPEAT_CYCLES out of range for CNT_W");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_EMIT     = 3'd2,
    S_HOLD     = 3'd3,
    S_ERR      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [9:0]       r_key,   w_key_nxt;
  logic [3:0]       r_digit, w_digit_nxt;

  logic [3:0]       w_ones;      // number of keys currently pressed
  logic [3:0]       w_key_idx;   // BCD index of the latched key
  logic             w_single;
  logic             w_zero;
  logic             w_match;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] c_rep_last = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] r_rcnt, w_rcnt_nxt;
`endif

  // Count pressed lines so single and multi-key presses can be told apart.
  always_comb begin
    w_ones = 4'd0;
    for (int i = 0; i < 10; i++) begin
      w_ones = w_ones + {3'd0, keypad[i]};
    end
  end

  // The latched key is one-hot, so ORing the indices of set bits yields the code.
  always_comb begin
    w_key_idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (r_key[i]) begin
        w_key_idx = w_key_idx | 4'(i);
      end
    end
  end

  assign w_single = (w_ones == 4'd1);
  assign w_zero   = (keypad == 10'd0);
  assign w_match  = (keypad == r_key);

  // Next-state, counter and data-path decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_key_nxt   = r_key;
    w_digit_nxt = r_digit;
`ifdef KEYPAD_AUTOREPEAT_EN
    w_rcnt_nxt  = r_rcnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_zero) begin
          w_cnt_nxt = '0;
          if (w_single) begin
            w_key_nxt   = keypad;
            w_state_nxt = S_DEBOUNCE;
          end else begin
            w_state_nxt = S_ERR;
          end
        end
      end
      S_DEBOUNCE: begin
        // Any deviation from the latched key, even on the final sample, aborts.
        if (w_match) begin
          if (r_cnt == c_deb_last) begin
            w_state_nxt = S_EMIT;
            w_digit_nxt = w_key_idx;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EMIT: begin
        w_state_nxt = S_HOLD;
        w_cnt_nxt   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
        w_rcnt_nxt  = '0;
`endif
      end
      S_HOLD: begin
        if (w_zero) begin
`ifdef KEYPAD_AUTOREPEAT_EN
          w_rcnt_nxt = '0;
`endif
          if (r_cnt == c_deb_last) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else if (w_match) begin
          // Key seen again: the preceding zeros were release bounce.
          w_cnt_nxt = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
          if (r_rcnt == c_rep_last) begin
            w_state_nxt = S_EMIT;
            w_digit_nxt = w_key_idx;
            w_rcnt_nxt  = '0;
          end else begin
            w_rcnt_nxt = r_rcnt + 1'b1;
          end
`endif
        end else begin
          w_state_nxt = S_ERR;
          w_cnt_nxt   = '0;
        end
      end
      S_ERR: begin
        // Leave only after a full debounce window of released lines.
        if (w_zero) begin
          if (r_cnt == c_deb_last) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and data registers; clear overrides every transition.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_key   <= '0;
      r_digit <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rcnt  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_key   <= w_key_nxt;
      r_digit <= w_digit_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rcnt  <= w_rcnt_nxt;
`endif
    end
  end

  assign digit = r_digit;
  assign valid = (r_state == S_EMIT);
  assign error = (r_state == S_ERR);
  assign busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_keypad_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_encoder
//  Description : Self-checking bench for keypad_encoder. Directed scenarios
//                followed by random keypad segments, compared every cycle
//                against a history-based reference model.
//                KEYPAD_AUTOREPEAT_EN selects the auto-repeat expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_encoder;

  localparam int D = 4;
  localparam int R = 16;

  logic       clk;
  logic       clear;
  logic [9:0] keypad;
  logic [3:0] digit;
  logic       valid;
  logic       busy;
  logic       error;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  keypad_encoder #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_CYCLES   (R),
    .CNT_W           (8)
  ) u_dut (
    .clk    (clk),
    .clear  (clear),
    .keypad (keypad),
    .digit  (digit),
    .valid  (valid),
    .busy   (busy),
    .error  (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Reference model: keeps the full sample history and decides strobes and
  // releases by measuring runs of identical samples in that history.
  // ---------------------------------------------------------------------
  localparam int P_QUIET = 0;   // nothing engaged
  localparam int P_ARM   = 1;   // single key waiting for D+1 identical samples
  localparam int P_HELD  = 2;   // key accepted, waiting for release
  localparam int P_FAULT = 3;   // multi-key, waiting for release

  logic [9:0] hist[$];
  int         phase   = P_QUIET;
  int         t_start = 0;      // history index where the press began
  int         t_from  = 0;      // first history index that counts towards runs
  logic [9:0] m_key   = '0;
  logic [3:0] m_digit = '0;
  logic       m_valid = 1'b0;

  function automatic int trail(input int n, input int lo, input logic [9:0] v);
    int c = 0;
    for (int i = n; i >= lo; i--) begin
      if (hist[i] != v) break;
      c++;
    end
    return c;
  endfunction

  function automatic logic [3:0] key_index(input logic [9:0] k);
    logic [3:0] r = 4'd0;
    for (int i = 0; i < 10; i++) if (k[i]) r = 4'(i);
    return r;
  endfunction

  task automatic model_edge(input logic [9:0] kp, input logic clr);
    int n;
    hist.push_back(kp);
    n = hist.size() - 1;
    m_valid = 1'b0;
    if (clr) begin
      phase   = P_QUIET;
      m_digit = 4'd0;
      return;
    end
    case (phase)
      P_QUIET: begin
        if (kp != 10'd0) begin
          if ($countones(kp) == 1) begin
            phase = P_ARM; t_start = n; m_key = kp;
          end else begin
            phase = P_FAULT; t_from = n + 1;
          end
        end
      end
      P_ARM: begin
        if (kp != m_key) phase = P_QUIET;
        else if (n - t_start == D) begin
          m_valid = 1'b1; m_digit = key_index(m_key);
          phase = P_HELD; t_from = n + 2;   // strobe cycle ignores its sample
        end
      end
      P_HELD: begin
        if (n >= t_from) begin
          if (kp == 10'd0) begin
            if (trail(n, t_from, 10'd0) == D) phase = P_QUIET;
          end else if (kp == m_key) begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if (trail(n, t_from, m_key) == R) begin
              m_valid = 1'b1; m_digit = key_index(m_key); t_from = n + 2;
            end
`endif
          end else begin
            phase = P_FAULT; t_from = n + 1;
          end
        end
      end
      default: begin
        if (kp == 10'd0 && trail(n, t_from, 10'd0) == D) phase = P_QUIET;
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock edge: drive, let the DUT sample, advance the model, compare.
  task automatic step(input logic [9:0] kp, input logic clr);
    keypad = kp;
    clear  = clr;
    @(posedge clk);
    cyc++;
    model_edge(kp, clr);
    #1;
    check("valid", {31'd0, valid}, {31'd0, m_valid});
    check("busy",  {31'd0, busy},  {31'd0, phase != P_QUIET});
    check("error", {31'd0, error}, {31'd0, phase == P_FAULT});
    check("digit", {28'd0, digit}, {28'd0, m_digit});
  endtask

  int         pulses;
  logic [9:0] v;
  int         len;
  int         a, b, sel;

  initial begin
    keypad = '0;
    clear  = 1'b1;

    // Reset with keypad idle.
    step(10'd0, 1'b1);
    step(10'd0, 1'b1);
    check("rst_digit", {28'd0, digit}, 32'd0);
    check("rst_busy",  {31'd0, busy},  32'd0);
    step(10'd0, 1'b0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Key 3 held for E0..E7, then released.
    for (int i = 0; i < 8; i++) begin
      step(10'h008, 1'b0);
      if (i == 3) check("t2_novalid_e3", {31'd0, valid}, 32'd0);
      if (i == 4) begin
        check("t2_valid_e4", {31'd0, valid}, 32'd1);
        check("t2_digit_e4", {28'd0, digit}, 32'd3);
      end
      if (i == 5) check("t2_single_pulse", {31'd0, valid}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      step(10'd0, 1'b0);
      if (i == 2) check("t2_busy_3z", {31'd0, busy}, 32'd1);
      if (i == 3) check("t2_busy_4z", {31'd0, busy}, 32'd0);
    end

    // Short bounce on key 7: no strobe, digit unchanged.
    pulses = 0;
    step(10'h080, 1'b0); pulses += int'(valid);
    step(10'h080, 1'b0); pulses += int'(valid);
    step(10'd0,   1'b0); pulses += int'(valid);
    check("t3_pulses", pulses, 32'd0);
    check("t3_busy",   {31'd0, busy},  32'd0);
    check("t3_digit",  {28'd0, digit}, 32'd3);

    // Two keys at once, then release.
    step(10'h003, 1'b0);
    check("t4_error", {31'd0, error}, 32'd1);
    check("t4_valid", {31'd0, valid}, 32'd0);
    for (int i = 0; i < 4; i++) step(10'd0, 1'b0);
    check("t4_error_clr", {31'd0, error}, 32'd0);
    check("t4_busy_clr",  {31'd0, busy},  32'd0);

    // Key 5 accepted, then a second key joins while held.
    for (int i = 0; i < 6; i++) step(10'h020, 1'b0);
    check("t5_digit", {28'd0, digit}, 32'd5);
    step(10'h021, 1'b0);
    check("t5_error", {31'd0, error}, 32'd1);
    check("t5_nostrobe", {31'd0, valid}, 32'd0);
    for (int i = 0; i < 4; i++) step(10'd0, 1'b0);

    // Clear while key 5 is held.
    for (int i = 0; i < 8; i++) step(10'h020, 1'b0);
    step(10'h020, 1'b1);
    check("t5_clr_busy",  {31'd0, busy},  32'd0);
    check("t5_clr_digit", {28'd0, digit}, 32'd0);
    for (int i = 0; i < 4; i++) step(10'd0, 1'b0);

    // Key 9 held for 40 edges: pulse count depends on auto-repeat.
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step(10'h200, 1'b0);
      if (valid) begin
        pulses++;
        check("t6_digit", {28'd0, digit}, 32'd9);
      end
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    check("t6_pulses", pulses, 32'd3);
`else
    check("t6_pulses", pulses, 32'd1);
`endif
    for (int i = 0; i < 6; i++) step(10'd0, 1'b0);

    // Random segments of held values, with bounce and occasional clear.
    for (int s = 0; s < 400; s++) begin
      sel = int'($urandom_range(0, 99));
      len = (($urandom_range(0, 9)) == 0) ? int'($urandom_range(15, 45))
                                          : int'($urandom_range(1, 9));
      a = int'($urandom_range(0, 9));
      if (sel < 35) begin
        v = 10'd0;
      end else if (sel < 78) begin
        v = 10'd1 << a;
      end else if (sel < 96) begin
        b = (a + 1 + int'($urandom_range(0, 8))) % 10;
        v = (10'd1 << a) | (10'd1 << b);
        if ($urandom_range(0, 1) == 1) v = v | 10'($urandom);
      end else begin
        step(10'($urandom), 1'b1);
        continue;
      end
      for (int k = 0; k < len; k++) step(v, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
